// File: rtl/tia_playfield_scheduler.sv
// tia_playfield_scheduler
//   Runs the horizontal color-clock counter across one scanline and picks
//   which of the 20 playfield bits drives each 4-clock pixel group. The left
//   half of the visible line is always shown in normal order. The right half
//   is either repeated or reflected, depending on CTRLPF.REF.
//
// Ports
//   clkp      in   1  color clock, rising edge
//   reset     in   1  asynchronous, active-high
//   we        in   1  bus write strobe
//   addr      in   6  0x0A CTRLPF, 0x0D PF0, 0x0E PF1, 0x0F PF2
//   d         in   8  bus write data
//   rsync     in   1  restart the line (hcount -> 0)
//   late_hb   in   1  arm an extended blank for the next line
//   hcount    out  8  color-clock position 0..LINE_CLOCKS-1
//   hblank    out  1  horizontal blank, possibly extended
//   pf_index  out  5  playfield bit selected this clock, 0 in blank
//   pf        out  1  registered playfield pixel
//
// LINE_CLOCKS must not exceed 256, because hcount is 8 bits wide.

// Playfield register file. PF0 keeps only the upper nibble that was written.
module tia_pf_regs (
  input  logic       clkp,
  input  logic       reset,
  input  logic       we,
  input  logic [5:0] addr,
  input  logic [7:0] d,
  output logic [3:0] pf0,
  output logic [7:0] pf1,
  output logic [7:0] pf2,
  output logic       ref_en
);

  localparam logic [5:0] ADDR_CTRLPF = 6'h0A;
  localparam logic [5:0] ADDR_PF0    = 6'h0D;
  localparam logic [5:0] ADDR_PF1    = 6'h0E;
  localparam logic [5:0] ADDR_PF2    = 6'h0F;

  always_ff @(posedge clkp or posedge reset) begin
    if (reset) begin
      pf0    <= '0;
      pf1    <= '0;
      pf2    <= '0;
      ref_en <= 1'b0;
    end else if (we) begin
      case (addr)
        ADDR_CTRLPF: ref_en <= d[0];
        ADDR_PF0:    pf0    <= d[7:4];
        ADDR_PF1:    pf1    <= d;
        ADDR_PF2:    pf2    <= d;
        default:     ;
      endcase
    end
  end

endmodule

module tia_playfield_scheduler #(
  parameter int LINE_CLOCKS    = 228,
  parameter int HBLANK_CLOCKS  = 68,
  parameter int LATE_HB_EXTRA  = 8,
  parameter int CLOCKS_PER_BIT = 4
) (
  input  logic       clkp,
  input  logic       reset,
  input  logic       we,
  input  logic [5:0] addr,
  input  logic [7:0] d,
  input  logic       rsync,
  input  logic       late_hb,
  output logic [7:0] hcount,
  output logic       hblank,
  output logic [4:0] pf_index,
  output logic       pf
);

  logic [3:0] pf0;
  logic [7:0] pf1;
  logic [7:0] pf2;
  logic       ref_en;

  logic [7:0] hcount_q;
  logic       armed_q;
  logic       ext_q;
  logic       pf_q;

  logic       wrap;
  logic       line_start;
  logic [8:0] blank_end;
  logic [7:0] vis_pos;
  logic [7:0] group;
  logic       right_half;
  logic [4:0] half_bit;
  logic [4:0] bit_sel;
  logic       sel_bit;

  tia_pf_regs u_regs (
    .clkp   (clkp),
    .reset  (reset),
    .we     (we),
    .addr   (addr),
    .d      (d),
    .pf0    (pf0),
    .pf1    (pf1),
    .pf2    (pf2),
    .ref_en (ref_en)
  );

  assign wrap       = (hcount_q == 8'(LINE_CLOCKS - 1));
  assign line_start = rsync | wrap;

  // The extended blank only widens the mask. The bit map is still anchored
  // at HBLANK_CLOCKS, so the first visible group becomes bit 2.
  assign blank_end = ext_q ? 9'(HBLANK_CLOCKS + LATE_HB_EXTRA)
                           : 9'(HBLANK_CLOCKS);
  assign hblank    = ({1'b0, hcount_q} < blank_end);

  // The subtraction is guarded by hblank, so vis_pos never wraps negative.
  assign vis_pos    = hblank ? 8'd0 : (hcount_q - 8'(HBLANK_CLOCKS));
  assign group      = vis_pos / 8'(CLOCKS_PER_BIT);
  assign right_half = (group >= 8'd20);
  assign half_bit   = right_half ? 5'(group - 8'd20) : group[4:0];
  assign bit_sel    = (right_half && ref_en) ? (5'd19 - half_bit) : half_bit;

  // Bit order on screen: PF0[4..7], PF1[7..0], PF2[0..7].
  always_comb begin
    sel_bit = 1'b0;
    if (bit_sel < 5'd4) begin
      sel_bit = pf0[bit_sel[1:0]];
    end else if (bit_sel < 5'd12) begin
      sel_bit = pf1[3'(5'd11 - bit_sel)];
    end else begin
      sel_bit = pf2[3'(bit_sel - 5'd12)];
    end
  end

  // On a line start, the arm flag moves into ext. A late_hb pulse in the same
  // clock re-arms the flag, so it applies to the line after this one.
  always_ff @(posedge clkp or posedge reset) begin
    if (reset) begin
      hcount_q <= '0;
      armed_q  <= 1'b0;
      ext_q    <= 1'b0;
      pf_q     <= 1'b0;
    end else begin
      hcount_q <= line_start ? 8'd0 : (hcount_q + 8'd1);
      if (line_start) begin
        ext_q   <= armed_q;
        armed_q <= late_hb;
      end else if (late_hb) begin
        armed_q <= 1'b1;
      end
      // An rsync blanks the pixel straight away, instead of letting the
      // pixel at the abandoned position through for one more clock.
      pf_q <= (hblank || rsync) ? 1'b0 : sel_bit;
    end
  end

  assign hcount   = hcount_q;
  assign pf_index = hblank ? 5'd0 : bit_sel;
  assign pf       = pf_q;

endmodule

// File: tb/tb_tia_playfield_scheduler.sv
module tb_tia_playfield_scheduler;

  logic       clkp = 1'b0;
  logic       reset;
  logic       we;
  logic [5:0] addr;
  logic [7:0] d;
  logic       rsync;
  logic       late_hb;
  logic [7:0] hcount;
  logic       hblank;
  logic [4:0] pf_index;
  logic       pf;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  int         m_h;
  bit         m_arm, m_ext, m_ref, m_pf;
  logic [7:0] m_pf0, m_pf1, m_pf2;

  tia_playfield_scheduler dut (
    .clkp     (clkp),
    .reset    (reset),
    .we       (we),
    .addr     (addr),
    .d        (d),
    .rsync    (rsync),
    .late_hb  (late_hb),
    .hcount   (hcount),
    .hblank   (hblank),
    .pf_index (pf_index),
    .pf       (pf)
  );

  always #5 clkp = ~clkp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_blank();
    return m_h < 68 + (m_ext ? 8 : 0);
  endfunction

  function automatic int m_bit_no();
    int n;
    if (m_blank()) return 0;
    n = (m_h - 68) / 4;
    if (n >= 20) begin
      n = n - 20;
      if (m_ref) n = 19 - n;
    end
    return n;
  endfunction

  function automatic bit m_pixel(input int n);
    bit field [20];
    for (int i = 0; i < 4; i++) field[i] = m_pf0[4 + i];
    for (int i = 0; i < 8; i++) field[4 + i] = m_pf1[7 - i];
    for (int i = 0; i < 8; i++) field[12 + i] = m_pf2[i];
    return field[n];
  endfunction

  task automatic model_reset();
    m_h = 0; m_arm = 0; m_ext = 0; m_ref = 0; m_pf = 0;
    m_pf0 = 0; m_pf1 = 0; m_pf2 = 0;
  endtask

  // Called at a negedge. It checks the outputs against the model, drives the
  // inputs for this cycle, advances the model and moves to the next negedge.
  task automatic step(input bit w = 0, input logic [5:0] a = 0,
                      input logic [7:0] dd = 0, input bit rs = 0, input bit lh = 0);
    bit ls;
    bit new_pf;
    chk("hcount", 32'(hcount), 32'(m_h));
    chk("hblank", 32'(hblank), 32'(m_blank()));
    chk("pf_index", 32'(pf_index), 32'(m_bit_no()));
    chk("pf", 32'(pf), 32'(m_pf));
    we = w; addr = a; d = dd; rsync = rs; late_hb = lh;
    ls = rs || (m_h == 227);
    new_pf = (m_blank() || rs) ? 1'b0 : m_pixel(m_bit_no());
    m_h = ls ? 0 : m_h + 1;
    if (ls) begin
      m_ext = m_arm;
      m_arm = lh;
    end else if (lh) begin
      m_arm = 1;
    end
    if (w) begin
      case (a)
        6'h0A: m_ref = dd[0];
        6'h0D: m_pf0 = dd & 8'hF0;
        6'h0E: m_pf1 = dd;
        6'h0F: m_pf2 = dd;
        default: ;
      endcase
    end
    m_pf = new_pf;
    @(posedge clkp);
    @(negedge clkp);
  endtask

  task automatic run_to(input int h);
    int guard = 0;
    while (32'(hcount) != h && guard < 600) begin
      step();
      guard++;
    end
    chk("reach_hcount", 32'(hcount), 32'(h));
  endtask

  // Counts the pf=1 cycles that belong to hcount 0..227 of the line starting now.
  task automatic count_line(input string tag, input int exp_ones);
    int ones = 0;
    chk({tag, "_start"}, 32'(hcount), 32'd0);
    for (int i = 0; i < 228; i++) begin
      step();
      ones += int'(pf);
    end
    chk(tag, 32'(ones), 32'(exp_ones));
  endtask

  initial begin
    reset = 1; we = 0; addr = 0; d = 0; rsync = 0; late_hb = 0;
    model_reset();
    repeat (2) @(negedge clkp);
    chk("rst_hcount", 32'(hcount), 32'd0);
    chk("rst_hblank", 32'(hblank), 32'd1);
    chk("rst_pf_index", 32'(pf_index), 32'd0);
    chk("rst_pf", 32'(pf), 32'd0);
    reset = 0;

    // Free run with an empty playfield: hcount wraps and pf stays 0.
    count_line("empty_line", 0);
    chk("wrap_hcount", 32'(hcount), 32'd0);

    // PF0 bit 4 only: 68..71 and 148..151.
    step(1, 6'h0D, 8'h10);
    run_to(0);
    count_line("pf0_bit0", 8);

    // PF2 bit 7 (playfield bit 19), reflected and then repeated.
    step(1, 6'h0D, 8'h00);
    step(1, 6'h0F, 8'h80);
    step(1, 6'h0A, 8'h01);
    run_to(0);
    count_line("pf2_bit19_ref", 8);
    step(1, 6'h0A, 8'h00);
    run_to(0);
    count_line("pf2_bit19_rep", 8);

    // Extended blank hides the left bit 0. The line after it is normal.
    step(1, 6'h0F, 8'h00);
    step(1, 6'h0D, 8'h10);
    run_to(100);
    step(0, 0, 0, 0, 1);
    run_to(0);
    count_line("late_hb_line", 4);
    count_line("after_late_hb", 8);

    // A write during the bit 4 window takes effect one evaluation later.
    step(1, 6'h0D, 8'h00);
    run_to(84);
    step(1, 6'h0E, 8'hFF);
    chk("pf1_wr_c85", 32'(pf), 32'd0);
    step();
    chk("pf1_wr_c86", 32'(pf), 32'd1);

    // rsync mid-line.
    run_to(150);
    step(0, 0, 0, 1, 0);
    chk("rsync_hcount", 32'(hcount), 32'd0);
    chk("rsync_pf", 32'(pf), 32'd0);
    count_line("post_rsync", 64);

    // Asynchronous reset mid-line.
    run_to(120);
    reset = 1;
    #1;
    chk("mid_rst_hcount", 32'(hcount), 32'd0);
    chk("mid_rst_hblank", 32'(hblank), 32'd1);
    chk("mid_rst_pf", 32'(pf), 32'd0);
    model_reset();
    @(negedge clkp);
    reset = 0;
    count_line("after_reset", 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit w, rs, lh;
      logic [5:0] a;
      w  = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 199) == 0);
      lh = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 4))
        0: a = 6'h0A;
        1: a = 6'h0D;
        2: a = 6'h0E;
        3: a = 6'h0F;
        default: a = 6'($urandom);
      endcase
      step(w, a, 8'($urandom), rs, lh);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
